// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
//   Shared definitions for the memory bus controller slice: default widths,
//   the wait-counter width and the controller FSM state encoding.
//   Imported by mem_wait_counter and mem_bus_ctrl.
package mem_bus_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 9;
  localparam int MEM_DEPTH_DEF   = 512;
  localparam int RAM_LATENCY_DEF = 2;

  // RAM_LATENCY is limited to 1..15, so four bits hold any wait count.
  localparam int LAT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_RD_CAP  = 3'd2,
    ST_WR_WAIT = 3'd3,
    ST_DONE    = 3'd4
  } mem_state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter
//   Loadable down-counter with a zero flag, used to pace RAM wait states for
//   both reads and writes.
// Ports:
//   Clock      in   system clock
//   Reset      in   synchronous active-high reset (count -> 0)
//   load       in   load load_value at the next edge (priority over dec)
//   load_value in   value to load
//   dec        in   decrement at the next edge; saturates at zero
//   zero       out  count is zero
module mem_wait_counter
  import mem_bus_pkg::*;
#(
  parameter int WIDTH = LAT_W
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;

  // Load wins over decrement; decrement never wraps below zero.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
//   Memory-side datapath stage behind the CPU control unit. Owns MAR and MDR,
//   turns rising edges of the control strobes into single RAM transactions
//   against a fixed-latency synchronous RAM, and reports completion.
// Optional build macro:
//   MEM_BUS_ERR_EN  range check against MEM_DEPTH; out-of-range accesses
//                   suppress the RAM strobe, reads return 0, bus_err is sticky.
//                   Undefined: addresses wrap modulo 2^ADDR_W, bus_err = 0.
// Ports:
//   Clock, Reset    clock and synchronous active-high reset
//   BusMuxOut       shared bus value (MAR / MDR load source)
//   MAR_enable      load MAR from BusMuxOut[ADDR_W-1:0]
//   MDR_enable      MDR load strobe; with MDR_read selects RAM or bus source
//   MDR_read        1 = read from RAM, 0 = load from bus
//   RAM_write       request write of MDR to RAM[MAR]
//   MDR_data        current MDR
//   mem_ready       one-cycle pulse when a RAM access completes
//   busy            a RAM access is in flight
//   bus_err         sticky out-of-range error
//   ram_addr/ram_wdata/ram_we/ram_re/ram_rdata   RAM interface
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int RAM_LATENCY = RAM_LATENCY_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MAR_enable,
  input  logic              MDR_enable,
  input  logic              MDR_read,
  input  logic              RAM_write,
  output logic [DATA_W-1:0] MDR_data,
  output logic              mem_ready,
  output logic              busy,
  output logic              bus_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata
);

  if ((MEM_DEPTH > (1 << ADDR_W)) || (RAM_LATENCY < 1) || (RAM_LATENCY > 15)) begin : g_bad_params
    $error("mem_bus_ctrl: illegal MEM_DEPTH or RAM_LATENCY");
  end

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic [DATA_W-1:0] rd_capture;
  logic              rd_level, rd_prev_q, wr_prev_q;
  logic              rd_req, wr_req;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              start_oor;

  // The control unit holds its strobes for a whole state, so only the first
  // cycle of each level counts as a request.
  assign rd_level = MDR_enable & MDR_read;
  assign rd_req   = rd_level & ~rd_prev_q;
  assign wr_req   = RAM_write & ~wr_prev_q;

  // Strobe history keeps sampling through reset so a level held across reset
  // does not look like a fresh edge afterwards.
  always_ff @(posedge Clock) begin
    rd_prev_q <= rd_level;
    wr_prev_q <= RAM_write;
  end

  // MAR follows the bus whenever enabled; the RAM latches the address at
  // strobe time, so changing it mid-transaction is harmless.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mar_q <= '0;
    end else if (MAR_enable) begin
      mar_q <= BusMuxOut[ADDR_W-1:0];
    end
  end

`ifdef MEM_BUS_ERR_EN
  logic rd_oor_q;
  logic bus_err_q;

  assign start_oor  = (int'(mar_q) >= MEM_DEPTH);
  assign rd_capture = rd_oor_q ? '0 : ram_rdata;
  assign bus_err    = bus_err_q;

  // Remember whether the accepted transaction was out of range; the read
  // path needs it later in RD_CAP, the error flag sticks until reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_oor_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && (rd_req || wr_req)) begin
      rd_oor_q <= start_oor;
      if (start_oor) begin
        bus_err_q <= 1'b1;
      end
    end
  end
`else
  assign start_oor  = 1'b0;
  assign rd_capture = ram_rdata;
  assign bus_err    = 1'b0;
`endif

  // MDR takes RAM data in RD_CAP; bus loads are honoured only when idle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mdr_q <= '0;
    end else if (state_q == ST_RD_CAP) begin
      mdr_q <= rd_capture;
    end else if ((state_q == ST_IDLE) && MDR_enable && !MDR_read) begin
      mdr_q <= BusMuxOut;
    end
  end

  mem_wait_counter #(
    .WIDTH(LAT_W)
  ) u_wait_counter (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (cnt_load),
    .load_value(LAT_W'(RAM_LATENCY - 1)),
    .dec       (cnt_dec),
    .zero      (cnt_zero)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Read has priority over a simultaneous write; the write is dropped.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          state_d  = ST_RD_WAIT;
          cnt_load = 1'b1;
        end else if (wr_req) begin
          state_d  = ST_WR_WAIT;
          cnt_load = 1'b1;
        end
      end
      ST_RD_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_RD_CAP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_RD_CAP: state_d = ST_DONE;
      ST_WR_WAIT: begin
        if (cnt_zero) begin
          state_d = ST_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // RAM strobes fire in the request cycle itself and are blocked during
  // reset so an abort never leaks a write.
  always_comb begin
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    mem_ready = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    if (!Reset && (state_q == ST_IDLE) && !start_oor) begin
      if (rd_req) begin
        ram_re = 1'b1;
      end else if (wr_req) begin
        ram_we = 1'b1;
      end
    end
  end

  assign MDR_data  = mdr_q;
  assign ram_addr  = mar_q;
  assign ram_wdata = mdr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
`timescale 1ns/1ps
// tb_mem_bus_ctrl
//   Randomized self-checking bench for mem_bus_ctrl with a behavioural RAM
//   and an expected-memory model. Build with MEM_BUS_ERR_EN to exercise the
//   range check (MEM_DEPTH is 256 here).
module tb_mem_bus_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [DW-1:0] BusMuxOut = '0;
  logic          MAR_enable = 1'b0;
  logic          MDR_enable = 1'b0;
  logic          MDR_read = 1'b0;
  logic          RAM_write = 1'b0;
  logic [DW-1:0] MDR_data;
  logic          mem_ready, busy, bus_err;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we, ram_re;
  logic [DW-1:0] ram_rdata;

  int checks = 0;
  int failures = 0;
  int we_count = 0;
  int re_count = 0;
  int rdy_count = 0;
  logic [AW-1:0] last_we_addr = '0;
  logic [DW-1:0] last_we_data = '0;
  logic [DW-1:0] exp_mem [512];

  mem_bus_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .RAM_LATENCY(LAT)
  ) dut (
    .Clock(Clock), .Reset(Reset), .BusMuxOut(BusMuxOut),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .MDR_read(MDR_read),
    .RAM_write(RAM_write), .MDR_data(MDR_data), .mem_ready(mem_ready),
    .busy(busy), .bus_err(bus_err), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
  );

  always #5 Clock = ~Clock;

  // Behavioural synchronous RAM: data appears LAT cycles after ram_re and
  // holds until the next read returns.
  logic [DW-1:0] mem [512];
  int rd_cd = 0;
  logic [AW-1:0] rd_addr_q = '0;
  always @(posedge Clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) begin
      rd_addr_q <= ram_addr;
      rd_cd <= LAT - 1;
    end else if (rd_cd == 1) begin
      ram_rdata <= mem[rd_addr_q];
      rd_cd <= 0;
    end else if (rd_cd > 1) begin
      rd_cd <= rd_cd - 1;
    end
  end

  // Pulse counters sampled mid-cycle.
  always @(negedge Clock) begin
    if (ram_we) begin
      we_count++;
      last_we_addr = ram_addr;
      last_we_data = ram_wdata;
    end
    if (ram_re) re_count++;
    if (mem_ready) rdy_count++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_mdr(input logic [DW-1:0] d);
    BusMuxOut = d; MDR_enable = 1'b1; MDR_read = 1'b0;
    tick();
    MDR_enable = 1'b0;
  endtask

  task automatic load_mar(input logic [AW-1:0] a);
    BusMuxOut = $urandom();
    BusMuxOut[AW-1:0] = a;
    MAR_enable = 1'b1;
    tick();
    MAR_enable = 1'b0;
  endtask

  task automatic run_write(input int hold, output int lat);
    RAM_write = 1'b1; lat = -1;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == hold) RAM_write = 1'b0;
      if (mem_ready && lat < 0) lat = c;
      if (lat >= 0 && c >= hold) break;
    end
    RAM_write = 1'b0;
    repeat (3) tick();
  endtask

  task automatic run_read(input int hold, output int lat, output logic [DW-1:0] m);
    MDR_enable = 1'b1; MDR_read = 1'b1; lat = -1; m = '0;
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (c == hold) begin MDR_enable = 1'b0; MDR_read = 1'b0; end
      if (mem_ready && lat < 0) begin lat = c; m = MDR_data; end
      if (lat >= 0 && c >= hold) break;
    end
    MDR_enable = 1'b0; MDR_read = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat;
    load_mdr(d);
    load_mar(a);
    run_write(1, lat);
    exp_mem[a] = d;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) tick();
    checks++; if (MDR_data !== '0) begin failures++; $display("[TB] FAIL reset_mdr got=%h exp=0", MDR_data); end
    checks++; if (ram_addr !== '0) begin failures++; $display("[TB] FAIL reset_mar got=%h exp=0", ram_addr); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%b exp=0", mem_ready); end
    checks++; if ({ram_we, ram_re} !== 2'b00) begin failures++; $display("[TB] FAIL reset_strobes got=%b exp=00", {ram_we, ram_re}); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_bus_err got=%b exp=0", bus_err); end
    Reset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_read();
    int rdy0;
    load_mdr(32'hDEAD_BEEF);
    load_mar(9'h010);
    rdy0 = rdy_count;
    MDR_enable = 1'b1; MDR_read = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL abort_busy_before got=%b exp=1", busy); end
    Reset = 1'b1; MDR_enable = 1'b0; MDR_read = 1'b0;
    tick();
    Reset = 1'b0;
    checks++; if (MDR_data !== '0) begin failures++; $display("[TB] FAIL abort_mdr got=%h exp=0", MDR_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL abort_busy got=%b exp=0", busy); end
    repeat (8) tick();
    checks++; if (rdy_count !== rdy0) begin failures++; $display("[TB] FAIL abort_no_ready got=%0d exp=%0d", rdy_count, rdy0); end
    checks++; if (we_count !== 0) begin failures++; $display("[TB] FAIL abort_no_we got=%0d exp=0", we_count); end
    checks++; if (MDR_data !== '0) begin failures++; $display("[TB] FAIL abort_mdr_late got=%h exp=0", MDR_data); end
  endtask

  task automatic test_write_read();
    logic [AW-1:0] a;
    logic [DW-1:0] d, m;
    int lat, we0, re0, whold, rhold;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        a = 9'h07F; d = 32'h0000_00A5; whold = 5; rhold = 4;
      end else begin
        a = AW'($urandom_range(0, DEPTH - 1)); d = $urandom();
        whold = $urandom_range(1, 6); rhold = $urandom_range(1, 6);
      end
      load_mdr(d);
      checks++; if (MDR_data !== d) begin failures++; $display("[TB] FAIL bus_load_mdr got=%h exp=%h", MDR_data, d); end
      load_mar(a);
      checks++; if (ram_addr !== a) begin failures++; $display("[TB] FAIL mar_load got=%h exp=%h", ram_addr, a); end
      we0 = we_count;
      run_write(whold, lat);
      exp_mem[a] = d;
      checks++; if (lat !== LAT + 1) begin failures++; $display("[TB] FAIL wr_latency got=%0d exp=%0d", lat, LAT + 1); end
      checks++; if (we_count - we0 !== 1) begin failures++; $display("[TB] FAIL wr_pulses got=%0d exp=1", we_count - we0); end
      checks++; if (last_we_addr !== a) begin failures++; $display("[TB] FAIL wr_addr got=%h exp=%h", last_we_addr, a); end
      checks++; if (last_we_data !== d) begin failures++; $display("[TB] FAIL wr_data got=%h exp=%h", last_we_data, d); end
      load_mdr(~d);
      re0 = re_count;
      run_read(rhold, lat, m);
      checks++; if (lat !== LAT + 2) begin failures++; $display("[TB] FAIL rd_latency got=%0d exp=%0d", lat, LAT + 2); end
      checks++; if (m !== exp_mem[a]) begin failures++; $display("[TB] FAIL rd_data got=%h exp=%h", m, exp_mem[a]); end
      checks++; if (re_count - re0 !== 1) begin failures++; $display("[TB] FAIL rd_pulses got=%0d exp=1", re_count - re0); end
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] m;
    int lat, we0, re0;
    do_write(9'h020, 32'h0000_1234);
    load_mdr(~32'h0000_1234);
    we0 = we_count; re0 = re_count;
    RAM_write = 1'b1;
    run_read(2, lat, m);
    RAM_write = 1'b0;
    tick();
    checks++; if (m !== exp_mem[9'h020]) begin failures++; $display("[TB] FAIL simul_data got=%h exp=%h", m, exp_mem[9'h020]); end
    checks++; if (lat !== LAT + 2) begin failures++; $display("[TB] FAIL simul_latency got=%0d exp=%0d", lat, LAT + 2); end
    checks++; if (we_count !== we0) begin failures++; $display("[TB] FAIL simul_no_we got=%0d exp=%0d", we_count, we0); end
    checks++; if (re_count - re0 !== 1) begin failures++; $display("[TB] FAIL simul_rd_pulses got=%0d exp=1", re_count - re0); end
  endtask

  task automatic test_busy_rejection();
    logic [AW-1:0] a, b;
    logic [DW-1:0] m;
    int lat, we0;
    a = 9'h055; b = 9'h0AA;
    do_write(a, $urandom());
    do_write(b, $urandom());
    load_mdr(~exp_mem[a]);
    load_mar(a);
    we0 = we_count;
    MDR_enable = 1'b1; MDR_read = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_in_wait got=%b exp=1", busy); end
    RAM_write = 1'b1; BusMuxOut = $urandom(); BusMuxOut[AW-1:0] = b; MAR_enable = 1'b1;
    tick();
    RAM_write = 1'b0; MAR_enable = 1'b0; MDR_enable = 1'b0; MDR_read = 1'b0;
    checks++; if (ram_addr !== b) begin failures++; $display("[TB] FAIL mar_while_busy got=%h exp=%h", ram_addr, b); end
    lat = -1; m = '0;
    for (int c = 3; c <= 24; c++) begin
      tick();
      if (mem_ready) begin lat = c; m = MDR_data; break; end
    end
    checks++; if (lat !== LAT + 2) begin failures++; $display("[TB] FAIL busy_rd_latency got=%0d exp=%0d", lat, LAT + 2); end
    checks++; if (m !== exp_mem[a]) begin failures++; $display("[TB] FAIL busy_rd_data got=%h exp=%h", m, exp_mem[a]); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_after got=%b exp=0", busy); end
    checks++; if (we_count !== we0) begin failures++; $display("[TB] FAIL busy_write_ignored got=%0d exp=%0d", we_count, we0); end
    load_mdr(~exp_mem[b]);
    run_read(2, lat, m);
    checks++; if (m !== exp_mem[b]) begin failures++; $display("[TB] FAIL busy_mem_unchanged got=%h exp=%h", m, exp_mem[b]); end
  endtask

  task automatic test_range();
    logic [DW-1:0] d, m;
    int lat, we0, re0;
    d = $urandom() | 32'h1;
    load_mdr(d);
    load_mar(9'h1F0);
    we0 = we_count;
    run_write(1, lat);
    checks++; if (lat !== LAT + 1) begin failures++; $display("[TB] FAIL range_wr_latency got=%0d exp=%0d", lat, LAT + 1); end
`ifdef MEM_BUS_ERR_EN
    checks++; if (we_count !== we0) begin failures++; $display("[TB] FAIL range_we_suppressed got=%0d exp=%0d", we_count, we0); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("[TB] FAIL range_bus_err got=%b exp=1", bus_err); end
    load_mdr(32'hFFFF_FFFF);
    re0 = re_count;
    run_read(1, lat, m);
    checks++; if (lat !== LAT + 2) begin failures++; $display("[TB] FAIL range_rd_latency got=%0d exp=%0d", lat, LAT + 2); end
    checks++; if (m !== '0) begin failures++; $display("[TB] FAIL range_rd_zero got=%h exp=0", m); end
    checks++; if (re_count !== re0) begin failures++; $display("[TB] FAIL range_re_suppressed got=%0d exp=%0d", re_count, re0); end
    we0 = we_count;
    do_write(9'h033, $urandom());
    checks++; if (we_count - we0 !== 1) begin failures++; $display("[TB] FAIL range_inrange_we got=%0d exp=1", we_count - we0); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("[TB] FAIL range_bus_err_sticky got=%b exp=1", bus_err); end
`else
    exp_mem[9'h1F0] = d;
    checks++; if (we_count - we0 !== 1) begin failures++; $display("[TB] FAIL wrap_we got=%0d exp=1", we_count - we0); end
    checks++; if (last_we_addr !== 9'h1F0) begin failures++; $display("[TB] FAIL wrap_addr got=%h exp=1f0", last_we_addr); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("[TB] FAIL wrap_bus_err got=%b exp=0", bus_err); end
    load_mdr(~d);
    re0 = re_count;
    run_read(1, lat, m);
    checks++; if (m !== exp_mem[9'h1F0]) begin failures++; $display("[TB] FAIL wrap_rd_data got=%h exp=%h", m, exp_mem[9'h1F0]); end
    checks++; if (re_count - re0 !== 1) begin failures++; $display("[TB] FAIL wrap_re got=%0d exp=1", re_count - re0); end
`endif
  endtask

  initial begin
    $display("[TB] starting mem_bus_ctrl bench");
    test_reset();
    test_reset_mid_read();
    test_write_read();
    test_simultaneous();
    test_busy_rejection();
    test_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory-side datapath stage directly downstream of the CPU control unit.
- Owns MAR and MDR and consumes the control unit's MAR_enable, MDR_enable, MDR_read and RAM_write strobes.
- Runs a wait-stated handshake against a fixed-latency synchronous RAM, drives MDR contents back toward the bus mux, and reports completion with mem_ready and busy.

Parameters:
- DATA_W, 32, data/bus width.
- ADDR_W, 9, MAR width (512-word space).
- MEM_DEPTH, 512, populated words; must be <= 2^ADDR_W.
- RAM_LATENCY, 2, cycles from ram_re to valid ram_rdata; legal range 1..15.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high reset.
- BusMuxOut  in  DATA_W  shared bus value.
- MAR_enable  in  1  load MAR from BusMuxOut[ADDR_W-1:0].
- MDR_enable  in  1  MDR load strobe.
- MDR_read  in  1  with MDR_enable: 1 = source is RAM, 0 = source is BusMuxOut.
- RAM_write  in  1  request write of MDR to RAM[MAR].
- MDR_data  out  DATA_W  current MDR, feeding the bus mux MDRout input.
- mem_ready  out  1  one-cycle pulse when a RAM read or write completes.
- busy  out  1  high while a RAM transaction is in flight.
- bus_err  out  1  sticky range error (see Optional Feature).
- ram_addr  out  ADDR_W  equals MAR.
- ram_wdata  out  DATA_W  equals MDR.
- ram_we  out  1  one-cycle write strobe.
- ram_re  out  1  one-cycle read strobe.
- ram_rdata  in  DATA_W  RAM read data, valid RAM_LATENCY cycles after ram_re.

Behaviour:
- Reset (synchronous, active-high):
  - MAR=0, MDR=0, state=IDLE, wait counter=0.
  - ram_we=0, ram_re=0, mem_ready=0, busy=0, bus_err=0.
  - Reset asserted mid-transaction aborts it. No mem_ready is produced, no ram_we is issued after the reset edge, and the pending read data is discarded.
- MAR: loads on any cycle with MAR_enable=1, independent of state. Changing MAR while busy does not alter the in-flight transaction, because the address is latched into the RAM at strobe time.
- MDR from bus: MDR_enable=1 and MDR_read=0 loads BusMuxOut at the next edge, only in IDLE; ignored while busy.
- Request detection is rising-edge based, because the control unit holds strobes for a full state:
  - rd_req = MDR_enable & MDR_read, high this cycle and low the previous cycle.
  - wr_req = RAM_write, high this cycle and low the previous cycle.
  - A level held after completion never retriggers.
- FSM states: IDLE, RD_WAIT, RD_CAP, WR_WAIT, DONE.
- IDLE:
  - rd_req: ram_re=1 for one cycle, go to RD_WAIT, counter=RAM_LATENCY-1.
  - wr_req (no rd_req): ram_we=1 for one cycle with ram_addr=MAR and ram_wdata=MDR, go to WR_WAIT, counter=RAM_LATENCY-1.
  - rd_req and wr_req together: read wins, the write is dropped (no queueing).
- RD_WAIT: decrement the counter; at 0 go to RD_CAP.
- RD_CAP: MDR<=ram_rdata, go to DONE.
- WR_WAIT: decrement the counter; at 0 go to DONE.
- DONE: mem_ready=1 for exactly one cycle, go to IDLE.
- busy=1 in RD_WAIT, RD_CAP, WR_WAIT and DONE.
- Latency:
  - Read, rd_req edge to mem_ready: RAM_LATENCY+2 cycles. MDR_data holds the new value in the mem_ready cycle.
  - Write, wr_req edge to mem_ready: RAM_LATENCY+1 cycles.
- Requests arriving while busy are ignored and not queued.

Optional Feature:
- Macro: MEM_BUS_ERR_EN.
- When defined:
  - A transaction with MAR >= MEM_DEPTH is out of range.
  - Write: ram_we is suppressed.
  - Read: ram_re is suppressed and MDR<=0 in RD_CAP.
  - Timing and mem_ready are unchanged.
  - bus_err sets and stays set until Reset.
- When undefined: no range check, the address wraps modulo 2^ADDR_W, and bus_err is tied 0.

Decomposition:
- Package mem_bus_pkg: FSM state enum (3-bit encoding), DATA_W/ADDR_W defaults, RAM_LATENCY width constant.
- One natural sub-module: mem_wait_counter, a loadable down-counter with a zero flag, reused by the read and write paths.

Test Plan:
- Reset mid-read: MAR=0x010, read started, Reset asserted in RD_WAIT -> MDR=0, busy=0, no mem_ready afterwards, no ram_we ever asserted.
- Bus load and write: BusMuxOut=0x0000_00A5 with MDR_enable=1 and MDR_read=0, then MAR=0x07F, then RAM_write raised -> ram_we pulses once with ram_addr=0x07F and ram_wdata=0xA5; mem_ready 3 cycles after the edge (RAM_LATENCY=2).
- Read back: MAR=0x07F, MDR_enable=1 and MDR_read=1 held for 4 cycles -> exactly one ram_re; MDR_data=0xA5 when mem_ready pulses 4 cycles after the edge; no second read.
- Simultaneous request: rd_req and wr_req on the same cycle with MAR=0x020 and RAM[0x020]=0x1234 -> read performed, MDR=0x1234, ram_we never asserted.
- Busy rejection: RAM_write edge while in RD_WAIT -> ignored; after mem_ready, RAM contents unchanged and busy=0.
- MEM_BUS_ERR_EN, MEM_DEPTH=256: write to MAR=0x1F0 -> no ram_we, bus_err=1, mem_ready still pulses; read from 0x1F0 -> MDR=0.
